// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin acceptor: coin encoding, emitter states, event payload.
package coin_pkg;

    localparam int unsigned DEB_CYCLES_DEF = 4;
    localparam int unsigned GAP_CYCLES_DEF = 2;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        COIN_50   = 1'b0,
        COIN_1LEU = 1'b1
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } emit_state_t;

    typedef struct packed {
        logic  valid;
        coin_t kind;
    } coin_evt_t;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, optional debounce filter (COIN_DEBOUNCE_EN), arming, rise detect.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise_c
);

`ifdef COIN_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic [1:0] sync_q;
    logic [1:0] settle_q;
    logic       sync_c;
    logic       filt_c;
    logic       prev_q;
    logic       armed_q;

    assign sync_c = sync_q[1];

    // Arm only once the synchronizer holds real samples and the sensor is seen low,
    // so a sensor held high across reset release never yields a coin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            settle_q <= '0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            settle_q <= {settle_q[0], 1'b1};
            prev_q   <= filt_c;
            if (settle_q[1] && !sync_c && !filt_c) begin
                armed_q <= 1'b1;
            end
        end
    end

    generate
        if (DEB_EN && (DEB_CYCLES != 0)) begin : g_filter
            localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            logic [DW-1:0] cnt_q;
            logic          filt_q;

            // Level follows the synchronizer only after DEB_CYCLES consecutive mismatches.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else if (sync_c != filt_q) begin
                    if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                        filt_q <= sync_c;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign filt_c = filt_q;
        end else begin : g_bypass
            assign filt_c = sync_c;
        end
    endgenerate

    assign rise_c = filt_c & ~prev_q & armed_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: two filtered channels, event FIFO, pulse emitter (IDLE/EMIT/GAP).
// Optional debounce filtering is enabled by defining COIN_DEBOUNCE_EN.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic coin50_raw,
    input  logic coin1leu_raw,
    output logic load50bani,
    output logic load1leu,
    output logic coin_reject,
    output logic busy
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic rise50_c;
    logic rise1leu_c;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb50 (
        .clk    (clk),
        .rst    (rst),
        .raw    (coin50_raw),
        .rise_c (rise50_c)
    );

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1leu (
        .clk    (clk),
        .rst    (rst),
        .raw    (coin1leu_raw),
        .rise_c (rise1leu_c)
    );

    // Simultaneous events on both channels cancel each other.
    coin_evt_t ev_d;
    coin_evt_t ev_q;
    logic      both_c;

    always_comb begin
        ev_d.valid = rise50_c ^ rise1leu_c;
        ev_d.kind  = rise1leu_c ? COIN_1LEU : COIN_50;
    end

    assign both_c = rise50_c & rise1leu_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev_d;
        end
    end

    coin_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_n;
    logic           full_c;
    logic           push_c;
    logic           pop_c;
    coin_t          head_c;

    assign full_c = (count_q == CW'(FIFO_DEPTH));
    assign push_c = ev_q.valid & (~full_c | pop_c);
    assign head_c = mem_q[rd_ptr_q];

    always_comb begin
        count_n = count_q;
        if (push_c && !pop_c) begin
            count_n = count_q + CW'(1);
        end else if (!push_c && pop_c) begin
            count_n = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            count_q <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= ev_q.kind;
        end
    end

    emit_state_t   state_q;
    emit_state_t   state_n;
    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_cnt_n;
    logic          load50_q;
    logic          load50_n;
    logic          load1leu_q;
    logic          load1leu_n;
    logic          reject_q;
    logic          reject_n;
    logic          busy_q;
    logic          busy_n;

    // Emitter next-state and registered-output values.
    always_comb begin
        state_n    = state_q;
        gap_cnt_n  = gap_cnt_q;
        pop_c      = 1'b0;
        load50_n   = 1'b0;
        load1leu_n = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    state_n = ST_EMIT;
                    if (head_c == COIN_1LEU) begin
                        load1leu_n = 1'b1;
                    end else begin
                        load50_n = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                gap_cnt_n = '0;
                state_n   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        reject_n = both_c | (ev_q.valid & full_c & ~pop_c);
        busy_n   = (count_n != '0) || (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            load50_q   <= 1'b0;
            load1leu_q <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            gap_cnt_q  <= gap_cnt_n;
            load50_q   <= load50_n;
            load1leu_q <= load1leu_n;
            reject_q   <= reject_n;
            busy_q     <= busy_n;
        end
    end

    assign load50bani  = load50_q;
    assign load1leu    = load1leu_q;
    assign coin_reject = reject_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: default instance plus a GAP_CYCLES=20, DEB_CYCLES=1 instance.
module tb_coin_acceptor;

`ifdef COIN_DEBOUNCE_EN
    localparam int LAT   = 9;
    localparam int LAT_G = 6;
`else
    localparam int LAT   = 5;
    localparam int LAT_G = 5;
`endif

    typedef struct {
        int cyc;
        bit typ;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic c50, c1, g50, g1;
    logic l50, l1, rej, busy;
    logic gl50, gl1, grej, gbusy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   both_err = 1'b0;
    ev_t  mq[$];
    ev_t  gq[$];
    int   mrej[$];
    int   grejq[$];
    logic mbusy[int];

    coin_acceptor u_dut (
        .clk          (clk),
        .rst          (rst),
        .coin50_raw   (c50),
        .coin1leu_raw (c1),
        .load50bani   (l50),
        .load1leu     (l1),
        .coin_reject  (rej),
        .busy         (busy)
    );

    coin_acceptor #(.DEB_CYCLES(1), .GAP_CYCLES(20)) u_gap (
        .clk          (clk),
        .rst          (rst),
        .coin50_raw   (g50),
        .coin1leu_raw (g1),
        .load50bani   (gl50),
        .load1leu     (gl1),
        .coin_reject  (grej),
        .busy         (gbusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (l50)  mq.push_back('{cyc, 1'b0});
        if (l1)   mq.push_back('{cyc, 1'b1});
        if (gl50) gq.push_back('{cyc, 1'b0});
        if (gl1)  gq.push_back('{cyc, 1'b1});
        if (rej)  mrej.push_back(cyc);
        if (grej) grejq.push_back(cyc);
        if ((l50 && l1) || (gl50 && gl1)) both_err = 1'b1;
        mbusy[cyc] = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        mq.delete();
        gq.delete();
        mrej.delete();
        grejq.delete();
    endtask

    // Drives bit i of each wave during cycle k+i on the selected instance.
    task automatic run_wave(input bit sel, input logic [63:0] w50, input logic [63:0] w1,
                            input int n, output int k);
        logic v50, v1;
        k = cyc;
        for (int i = 0; i < n; i++) begin
            v50 = 1'b0;
            v1  = 1'b0;
            if (i < 64) begin
                v50 = w50[i];
                v1  = w1[i];
            end
            if (sel) begin
                g50 = v50;
                g1  = v1;
            end else begin
                c50 = v50;
                c1  = v1;
            end
            step();
        end
        c50 = 1'b0; c1 = 1'b0; g50 = 1'b0; g1 = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst = 1'b1;
        c50 = 1'b0; c1 = 1'b0; g50 = 1'b0; g1 = 1'b0;
        repeat (2) step();
        outs = {l50, l1, rej, busy, gl50, gl1, grej, gbusy};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_out[%0d] got %b exp 0", i, outs[i]);
            end
        end
        rst = 1'b0;
        repeat (8) step();
        clear_logs();
    endtask

    task automatic test_clean_50();
        int k;
        clear_logs();
        run_wave(1'b0, 64'h3FF, 64'h0, 30, k);
        checks++;
        if (mq.size() !== 1) begin
            failures++;
            $display("FAIL clean50_count got %0d exp 1", mq.size());
        end
        if (mq.size() > 0) begin
            checks++;
            if (mq[0].cyc !== k + LAT || mq[0].typ !== 1'b0) begin
                failures++;
                $display("FAIL clean50_pulse got cyc %0d typ %0d exp cyc %0d typ 0",
                         mq[0].cyc - k, mq[0].typ, LAT);
            end
        end
        checks++;
        if (mbusy[k+LAT-2] !== 1'b0) begin failures++; $display("FAIL clean50_busy_pre got %b exp 0", mbusy[k+LAT-2]); end
        checks++;
        if (mbusy[k+LAT-1] !== 1'b1) begin failures++; $display("FAIL clean50_busy_queued got %b exp 1", mbusy[k+LAT-1]); end
        checks++;
        if (mbusy[k+LAT+2] !== 1'b1) begin failures++; $display("FAIL clean50_busy_gap got %b exp 1", mbusy[k+LAT+2]); end
        checks++;
        if (mbusy[k+LAT+3] !== 1'b0) begin failures++; $display("FAIL clean50_busy_end got %b exp 0", mbusy[k+LAT+3]); end
    endtask

    task automatic test_bounce_1leu();
        int k;
        int exp_cyc[$];
        clear_logs();
        run_wave(1'b0, 64'h0, 64'h1FFD, 40, k);
`ifdef COIN_DEBOUNCE_EN
        exp_cyc.push_back(k + 11);
`else
        exp_cyc.push_back(k + 5);
        exp_cyc.push_back(k + 9);
`endif
        checks++;
        if (mq.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL bounce_count got %0d exp %0d", mq.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < mq.size(); i++) begin
            checks++;
            if (mq[i].cyc !== exp_cyc[i] || mq[i].typ !== 1'b1) begin
                failures++;
                $display("FAIL bounce_pulse[%0d] got cyc %0d typ %0d exp cyc %0d typ 1",
                         i, mq[i].cyc - k, mq[i].typ, exp_cyc[i] - k);
            end
        end
    endtask

    task automatic test_both_reject();
        int k;
        clear_logs();
        run_wave(1'b0, 64'h3FF, 64'h3FF, 30, k);
        checks++;
        if (mq.size() !== 0) begin failures++; $display("FAIL both_loads got %0d exp 0", mq.size()); end
        checks++;
        if (mrej.size() !== 1) begin failures++; $display("FAIL both_reject_count got %0d exp 1", mrej.size()); end
        if (mrej.size() > 0) begin
            checks++;
            if (mrej[0] !== k + LAT - 2) begin
                failures++;
                $display("FAIL both_reject_cyc got %0d exp %0d", mrej[0] - k, LAT - 2);
            end
        end
    endtask

    task automatic test_alternating();
        int k;
        clear_logs();
        run_wave(1'b0, 64'h1F01F01F, 64'h7C07C07C0, 60, k);
        checks++;
        if (mq.size() !== 6) begin failures++; $display("FAIL alt_count got %0d exp 6", mq.size()); end
        for (int i = 0; i < 6 && i < mq.size(); i++) begin
            checks++;
            if (mq[i].cyc !== k + LAT + 6 * i || mq[i].typ !== 1'(i % 2)) begin
                failures++;
                $display("FAIL alt_pulse[%0d] got cyc %0d typ %0d exp cyc %0d typ %0d",
                         i, mq[i].cyc - k, mq[i].typ, LAT + 6 * i, i % 2);
            end
        end
        checks++;
        if (mrej.size() !== 0) begin failures++; $display("FAIL alt_rejects got %0d exp 0", mrej.size()); end
    endtask

    // A primer coin occupies the emitter; six rapid coins follow: four fit, two overflow.
    task automatic test_overflow();
        int k;
        int og;
        int exp_c[5] = '{5, 27, 49, 71, 93};
        bit exp_t[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int exp_r[2] = '{15, 17};
        og = LAT_G - 5;
        clear_logs();
        run_wave(1'b1, 64'h6333, 64'h1998, 130, k);
        checks++;
        if (gq.size() !== 5) begin failures++; $display("FAIL ovf_count got %0d exp 5", gq.size()); end
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            checks++;
            if (gq[i].cyc !== k + exp_c[i] + og || gq[i].typ !== exp_t[i]) begin
                failures++;
                $display("FAIL ovf_pulse[%0d] got cyc %0d typ %0d exp cyc %0d typ %0d",
                         i, gq[i].cyc - k, gq[i].typ, exp_c[i] + og, exp_t[i]);
            end
        end
        checks++;
        if (grejq.size() !== 2) begin failures++; $display("FAIL ovf_reject_count got %0d exp 2", grejq.size()); end
        for (int i = 0; i < 2 && i < grejq.size(); i++) begin
            checks++;
            if (grejq[i] !== k + exp_r[i] + og) begin
                failures++;
                $display("FAIL ovf_reject[%0d] got %0d exp %0d", i, grejq[i] - k, exp_r[i] + og);
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        int k;
        int m;
        logic [3:0] outs;
        clear_logs();
        k = cyc;
        for (int i = 0; i < 27 + LAT_G - 5; i++) begin
            g50 = (i == 0 || i == 2 || i >= 4);
            g1  = (i == 1 || i == 2);
            step();
        end
        checks++;
        if (gl1 !== 1'b1 || gl50 !== 1'b0) begin
            failures++;
            $display("FAIL rst_emit_pre got l50 %b l1 %b exp l50 0 l1 1", gl50, gl1);
        end
        checks++;
        if (gq.size() !== 1) begin failures++; $display("FAIL rst_emit_first got %0d exp 1", gq.size()); end
        rst = 1'b1;
        #1;
        outs = {gl50, gl1, grej, gbusy};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs[i] !== 1'b0) begin
                failures++;
                $display("FAIL rst_emit_out[%0d] got %b exp 0", i, outs[i]);
            end
        end
        repeat (3) step();
        rst = 1'b0;
        clear_logs();
        repeat (40) step();
        checks++;
        if (gq.size() !== 0 || grejq.size() !== 0) begin
            failures++;
            $display("FAIL rst_held_events got %0d exp 0", gq.size() + grejq.size());
        end
        checks++;
        if (gbusy !== 1'b0) begin failures++; $display("FAIL rst_held_busy got %b exp 0", gbusy); end
        g50 = 1'b0;
        repeat (6) step();
        g50 = 1'b1;
        m = cyc;
        repeat (25) step();
        g50 = 1'b0;
        checks++;
        if (gq.size() !== 1) begin failures++; $display("FAIL rst_rearm_count got %0d exp 1", gq.size()); end
        if (gq.size() > 0) begin
            checks++;
            if (gq[0].cyc !== m + LAT_G || gq[0].typ !== 1'b0) begin
                failures++;
                $display("FAIL rst_rearm_pulse got cyc %0d typ %0d exp cyc %0d typ 0",
                         gq[0].cyc - m, gq[0].typ, LAT_G);
            end
        end
        if (k < 0) $display("unexpected negative start cycle");
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_err !== 1'b0) begin
            failures++;
            $display("FAIL exclusive_loads got %b exp 0", both_err);
        end
    endtask

    initial begin
        test_reset();
        test_clean_50();
        test_bounce_1leu();
        test_both_reject();
        test_alternating();
        test_overflow();
        test_reset_mid_emit();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
